// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit saturating-counter branch predictor with registered resolution
// Optional hit/miss statistics are compiled in with BPU_PERF_COUNTERS_EN.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     if_pc,
  output logic            predict_taken,
  input  logic            res_valid,
  input  logic [31:0]     res_pc,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [3:0]      select,
  input  logic            pred_in,
  input  logic            flush,
  output logic            out_valid,
  output logic            taken,
  output logic            mispredict
`ifdef BPU_PERF_COUNTERS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] res_idx;
  logic             accept;
  logic             is_cond;
  logic             outcome;
  logic [1:0]       cur_cnt;

  // Word-aligned PC: bits [1:0] and anything above the index never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

  assign if_idx        = if_pc[IDX_W+1:2];
  assign res_idx       = res_pc[IDX_W+1:2];
  assign predict_taken = bht[if_idx][1];
  assign cur_cnt       = bht[res_idx];

  assign accept  = res_valid & select[3] & ~flush;
  assign is_cond = (select[2:1] != 2'b01);

  always_comb begin
    outcome = 1'b0;
    case (select[2:0])
      3'b000:  outcome = (data1 == data2);
      3'b001:  outcome = (data1 != data2);
      3'b010:  outcome = 1'b1;
      3'b100:  outcome = ($signed(data1) <  $signed(data2));
      3'b101:  outcome = ($signed(data1) >= $signed(data2));
      3'b110:  outcome = (data1 <  data2);
      3'b111:  outcome = (data1 >= data2);
      default: outcome = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      out_valid  <= accept;
      taken      <= accept & outcome;
      mispredict <= accept & (outcome != pred_in);
      if (accept && is_cond) begin
        if (outcome)
          bht[res_idx] <= (cur_cnt == 2'b11) ? cur_cnt : cur_cnt + 2'd1;
        else
          bht[res_idx] <= (cur_cnt == 2'b00) ? cur_cnt : cur_cnt - 2'd1;
      end
    end
  end

`ifdef BPU_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_count   <= 32'd0;
      miss_count <= 32'd0;
    end else if (accept) begin
      if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
      if ((outcome != pred_in) && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed and randomized bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  select;
  logic        pred_in;
  logic        flush;
  logic        out_valid;
  logic        taken;
  logic        mispredict;
`ifdef BPU_PERF_COUNTERS_EN
  logic [31:0] br_count;
  logic [31:0] miss_count;
  logic [31:0] br_m;
  logic [31:0] miss_m;
`endif

  int passed = 0;
  int total  = 0;
  int bht_m [16];

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .if_pc         (if_pc),
    .predict_taken (predict_taken),
    .res_valid     (res_valid),
    .res_pc        (res_pc),
    .data1         (data1),
    .data2         (data2),
    .select        (select),
    .pred_in       (pred_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .taken         (taken),
    .mispredict    (mispredict)
`ifdef BPU_PERF_COUNTERS_EN
    ,
    .br_count      (br_count),
    .miss_count    (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic longint sval(input logic [31:0] x);
    if (x >= 32'h8000_0000) return longint'(x) - (longint'(1) << 32);
    return longint'(x);
  endfunction

  function automatic bit ref_taken(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b1;
      3'd4: return sval(a) <  sval(b);
      3'd5: return sval(a) >= sval(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
`ifdef BPU_PERF_COUNTERS_EN
    br_m   = 0;
    miss_m = 0;
`endif
  endtask

  task automatic step(input bit v, input logic [31:0] rpc, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [3:0] sel, input bit pr,
                      input bit fl, input logic [31:0] ipc);
    bit acc;
    bit t;
    int ri;
    @(negedge clk);
    res_valid = v; res_pc = rpc; data1 = d1; data2 = d2;
    select = sel; pred_in = pr; flush = fl; if_pc = ipc;
    #1;
    check("predict_taken", {31'd0, predict_taken}, {31'd0, bht_m[idx(ipc)] >= 2});
    acc = v && sel[3] && !fl;
    t   = ref_taken(sel, d1, d2);
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, acc});
    check("taken", {31'd0, taken}, {31'd0, acc && t});
    check("mispredict", {31'd0, mispredict}, {31'd0, acc && (t != pr)});
    ri = idx(rpc);
    if (acc && sel[2:1] != 2'b01) begin
      if (t) bht_m[ri] = (bht_m[ri] < 3) ? bht_m[ri] + 1 : 3;
      else   bht_m[ri] = (bht_m[ri] > 0) ? bht_m[ri] - 1 : 0;
    end
`ifdef BPU_PERF_COUNTERS_EN
    if (acc) begin
      if (br_m != 32'hFFFF_FFFF) br_m = br_m + 1;
      if (t != pr && miss_m != 32'hFFFF_FFFF) miss_m = miss_m + 1;
    end
    check("br_count", br_count, br_m);
    check("miss_count", miss_count, miss_m);
`endif
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, ipc);
  endtask

  initial begin
    resetn = 1'b0; if_pc = 0; res_valid = 0; res_pc = 0; data1 = 0; data2 = 0;
    select = 0; pred_in = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Three taken BEQs saturate entry 0 at strong-taken.
    idle(32'h40);
    repeat (3) step(1'b1, 32'h40, 32'd5, 32'd5, 4'b1000, 1'b0, 1'b0, 32'h40);
    idle(32'h40);
    check("beq_trained", {31'd0, predict_taken}, 32'd1);

    // Signed vs unsigned less-than on the same operands.
    step(1'b1, 32'h10, 32'hFFFF_FFFF, 32'd1, 4'b1100, 1'b0, 1'b0, 32'h0);
    check("blt_taken", {31'd0, taken}, 32'd1);
    step(1'b1, 32'h10, 32'hFFFF_FFFF, 32'd1, 4'b1110, 1'b0, 1'b0, 32'h0);
    check("bltu_taken", {31'd0, taken}, 32'd0);

    // Asynchronous reset pulse between two edges, right after an accepted branch.
    step(1'b1, 32'h48, 32'd1, 32'd2, 4'b1001, 1'b0, 1'b0, 32'h48);
    #1 resetn = 1'b0;
    #1;
    check("pulse_out_valid", {31'd0, out_valid}, 32'd0);
    check("pulse_taken", {31'd0, taken}, 32'd0);
    check("pulse_mispredict", {31'd0, mispredict}, 32'd0);
`ifdef BPU_PERF_COUNTERS_EN
    check("pulse_br_count", br_count, 32'd0);
    check("pulse_miss_count", miss_count, 32'd0);
`endif
    model_reset();
    res_valid = 1'b0;
    #1 resetn = 1'b1;
    for (int i = 0; i < 16; i++) idle(32'(i * 4));
    step(1'b1, 32'h0, 32'd3, 32'd3, 4'b1000, 1'b1, 1'b0, 32'h0);
    idle(32'h0);
    check("post_reset_weak_t", {31'd0, predict_taken}, 32'd1);
    step(1'b1, 32'h0, 32'd3, 32'd4, 4'b1000, 1'b1, 1'b0, 32'h0);
    idle(32'h0);

    // JAL never touches the table; flushed BNE is dropped.
    step(1'b1, 32'h80, 32'd0, 32'd0, 4'b1010, 1'b0, 1'b0, 32'h80);
    check("jal_mispredict", {31'd0, mispredict}, 32'd1);
    idle(32'h80);
    check("jal_entry_kept", {31'd0, predict_taken}, 32'd0);
    step(1'b1, 32'h80, 32'd1, 32'd2, 4'b1001, 1'b0, 1'b1, 32'h80);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    idle(32'h80);

    // Same-cycle lookup and update at one index: no bypass.
    step(1'b1, 32'h44, 32'd5, 32'd3, 4'b1101, 1'b0, 1'b0, 32'h44);
    idle(32'h44);
    check("bge_visible_next", {31'd0, predict_taken}, 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  s;
      a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a :
          (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom);
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) s[3] = 1'b1;
      step($urandom_range(0, 3) != 0, {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC | 32'(0),
           a, b, s, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
